// File: rtl/bcd_counter_4d.sv
// bcd_counter_4d: four-digit packed-BCD up/down counter with on-chip input
// synchronisers and a prescaler producing the count step.
// The digit-0 nibble sits in bcd_o[3:0] so the output feeds a 7-segment
// multiplexer's bcd input directly.
//
// Control priority each cycle: clear edge > load strobe > prescaler step.
// The tick_o and wrap_o flags are registered so they line up with the
// bcd_o change they describe.
module bcd_counter_4d #(
   parameter int TICK_COUNT  = 27000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        up_i,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   output logic [15:0] bcd_o,
   output logic        tick_o,
   output logic        wrap_o
);

   localparam int              PW           = $clog2(TICK_COUNT);
   localparam logic [PW-1:0]   PRESC_RELOAD = PW'(TICK_COUNT - 1);

   // Synchroniser chains; the oldest sample lives in the top bit
   logic [SYNC_STAGES-1:0] r_en_sync;
   logic [SYNC_STAGES-1:0] r_up_sync;
   logic [SYNC_STAGES-1:0] r_clr_sync;
   logic                   r_clr_d;

   logic                   w_en_s;
   logic                   w_up_s;
   logic                   w_clr_s;
   logic                   w_clr_pulse;

   // Prescaler and step
   logic [PW-1:0]          r_presc;
   logic                   w_step;

   // Count state and registered flags
   logic [15:0]            r_bcd;
   logic                   r_tick;
   logic                   r_wrap;

   // Next-value candidates
   logic [15:0]            w_inc_val;
   logic                   w_inc_carry;
   logic [15:0]            w_dec_val;
   logic                   w_dec_borrow;
   logic [15:0]            w_load_clamped;

   assign w_en_s      = r_en_sync[SYNC_STAGES-1];
   assign w_up_s      = r_up_sync[SYNC_STAGES-1];
   assign w_clr_s     = r_clr_sync[SYNC_STAGES-1];
   // One cycle per press no matter how long the button is held
   assign w_clr_pulse = w_clr_s & ~r_clr_d;

   // Shift the asynchronous switch/button levels through the synchronisers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_en_sync  <= '0;
         r_up_sync  <= '0;
         r_clr_sync <= '0;
         r_clr_d    <= 1'b0;
      end else begin
         r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], en_i};
         r_up_sync  <= {r_up_sync[SYNC_STAGES-2:0], up_i};
         r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], clr_i};
         r_clr_d    <= w_clr_s;
      end
   end

   // A step fires on the enabled cycle in which the prescaler has run out
   assign w_step = w_en_s & (r_presc == '0);

   // Prescaler: count down while enabled, hold phase while paused, restart on clear
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_presc <= PRESC_RELOAD;
      end else if (w_clr_pulse) begin
         r_presc <= PRESC_RELOAD;
      end else if (w_en_s) begin
         if (r_presc == '0) begin
            r_presc <= PRESC_RELOAD;
         end else begin
            r_presc <= r_presc - 1'b1;
         end
      end
   end

   // Ripple BCD increment; carry out of digit 3 means 9999 -> 0000
   always_comb begin
      w_inc_val   = r_bcd;
      w_inc_carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (w_inc_carry) begin
            if (r_bcd[d*4 +: 4] == 4'd9) begin
               w_inc_val[d*4 +: 4] = 4'd0;
            end else begin
               w_inc_val[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd1;
               w_inc_carry         = 1'b0;
            end
         end
      end
   end

   // Ripple BCD decrement; borrow out of digit 3 means 0000 -> 9999
   always_comb begin
      w_dec_val    = r_bcd;
      w_dec_borrow = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (w_dec_borrow) begin
            if (r_bcd[d*4 +: 4] == 4'd0) begin
               w_dec_val[d*4 +: 4] = 4'd9;
            end else begin
               w_dec_val[d*4 +: 4] = r_bcd[d*4 +: 4] - 4'd1;
               w_dec_borrow        = 1'b0;
            end
         end
      end
   end

   // Clamp each load nibble to 9 so the count never holds a non-BCD digit
   always_comb begin
      w_load_clamped = '0;
      for (int d = 0; d < 4; d++) begin
         if (load_val_i[d*4 +: 4] > 4'd9) begin
            w_load_clamped[d*4 +: 4] = 4'd9;
         end else begin
            w_load_clamped[d*4 +: 4] = load_val_i[d*4 +: 4];
         end
      end
   end

   // Count register: clear beats load, load beats (and drops) a coincident step
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_bcd  <= 16'h0000;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         if (w_clr_pulse) begin
            r_bcd <= 16'h0000;
         end else if (load_i) begin
            r_bcd <= w_load_clamped;
         end else if (w_step) begin
            r_tick <= 1'b1;
            if (w_up_s) begin
               r_bcd  <= w_inc_val;
               r_wrap <= w_inc_carry;
            end else begin
               r_bcd  <= w_dec_val;
               r_wrap <= w_dec_borrow;
            end
         end
      end
   end

   assign bcd_o  = r_bcd;
   assign tick_o = r_tick;
   assign wrap_o = r_wrap;

endmodule

// File: tb/tb_bcd_counter_4d.sv
// Bench for bcd_counter_4d with TICK_COUNT=4, SYNC_STAGES=2.
// A reference model (integer count, delay-line synchronisers, enabled-cycle
// counter) pushes the expected {bcd, tick, wrap} after every clock edge;
// a monitor pops and compares one cycle-entry per edge.
module tb_bcd_counter_4d;

  localparam int TICK = 4;
  localparam int SYNC = 2;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic        up_i;
  logic        clr_i;
  logic        load_i;
  logic [15:0] load_val_i;
  logic [15:0] bcd_o;
  logic        tick_o;
  logic        wrap_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];

  bcd_counter_4d #(
    .TICK_COUNT (TICK),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .up_i      (up_i),
    .clr_i     (clr_i),
    .load_i    (load_i),
    .load_val_i(load_val_i),
    .bcd_o     (bcd_o),
    .tick_o    (tick_o),
    .wrap_o    (wrap_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  int m_count;
  int m_en_cycles;
  int m_clr_prev;
  int m_en_q[$];
  int m_up_q[$];
  int m_clr_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] raw);
    int v;
    int nib;
    v = 0;
    for (int d = 3; d >= 0; d--) begin
      nib = int'(raw[d*4 +: 4]);
      if (nib > 9) nib = 9;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_count     = 0;
    m_en_cycles = 0;
    m_clr_prev  = 0;
    m_en_q.delete();
    m_up_q.delete();
    m_clr_q.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_en_q.push_back(0);
      m_up_q.push_back(0);
      m_clr_q.push_back(0);
    end
  endtask

  initial model_reset();

  always @(negedge rst_i) model_reset();

  always @(posedge clk_i) begin
    int en_s, up_s, clr_s, clr_pulse, step, tick, wrap;
    if (!rst_i) begin
      model_reset();
      exp_q.push_back(18'h0);
    end else begin
      en_s      = m_en_q[0];
      up_s      = m_up_q[0];
      clr_s     = m_clr_q[0];
      clr_pulse = (clr_s == 1 && m_clr_prev == 0) ? 1 : 0;
      step      = (en_s == 1 && m_en_cycles == TICK - 1) ? 1 : 0;
      tick      = 0;
      wrap      = 0;
      if (clr_pulse == 1) begin
        m_count     = 0;
        m_en_cycles = 0;
      end else begin
        if (en_s == 1) m_en_cycles = (step == 1) ? 0 : m_en_cycles + 1;
        if (load_i) begin
          m_count = clamp_val(load_val_i);
        end else if (step == 1) begin
          tick = 1;
          if (up_s == 1) begin
            wrap    = (m_count == 9999) ? 1 : 0;
            m_count = (m_count + 1) % 10000;
          end else begin
            wrap    = (m_count == 0) ? 1 : 0;
            m_count = (m_count + 9999) % 10000;
          end
        end
      end
      m_clr_prev = clr_s;
      void'(m_en_q.pop_front());
      void'(m_up_q.pop_front());
      void'(m_clr_q.pop_front());
      m_en_q.push_back(int'(en_i));
      m_up_q.push_back(int'(up_i));
      m_clr_q.push_back(int'(clr_i));
      exp_q.push_back({to_bcd(m_count), tick[0], wrap[0]});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk_i) begin
    logic [17:0] exp_v;
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty t=%0t got bcd=%h tick=%0b wrap=%0b, no expectation queued", $time, bcd_o, tick_o, wrap_o);
    end else begin
      exp_v = exp_q.pop_front();
      if ({bcd_o, tick_o, wrap_o} !== exp_v) begin
        n_fail++;
        $display("FAIL sb_cycle t=%0t got bcd=%h tick=%0b wrap=%0b, want bcd=%h tick=%0b wrap=%0b",
                 $time, bcd_o, tick_o, wrap_o, exp_v[17:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load_i     = 1'b1;
    load_val_i = v;
    @(negedge clk_i);
    load_i     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i      = 1'b0;
    en_i       = 1'b0;
    up_i       = 1'b0;
    clr_i      = 1'b0;
    load_i     = 1'b0;
    load_val_i = 16'h0000;
    cycles(3);
    check("reset_bcd", {16'h0, bcd_o}, 32'h0);
    check("reset_flags", {30'h0, tick_o, wrap_o}, 32'h0);
    rst_i = 1'b1;

    // Count up from zero across the 0009->0010 carry
    en_i = 1'b1;
    up_i = 1'b1;
    cycles(60);

    // 0099 -> 0100 carry
    do_load(16'h0097);
    cycles(16);

    // Wrap up 9999 -> 0000, then down 0000 -> 9999
    do_load(16'h9998);
    cycles(12);
    up_i = 1'b0;
    cycles(16);

    // 1000 down -> 0999
    do_load(16'h1000);
    cycles(10);

    // Pause mid-period for 10 cycles, then resume
    up_i = 1'b1;
    cycles(2);
    en_i = 1'b0;
    cycles(10);
    en_i = 1'b1;
    cycles(12);

    // Held clear at 0042: exactly one clear, three cycles after the edge
    do_load(16'h0042);
    clr_i = 1'b1;
    cycles(3);
    check("clr_latency", {16'h0, bcd_o}, 32'h0);
    cycles(17);
    clr_i = 1'b0;
    cycles(4);

    // Clamped load while paused
    en_i = 1'b0;
    cycles(4);
    do_load(16'hA5F3);
    check("load_clamp", {16'h0, bcd_o}, 32'h9593);

    // Clear and load in the same cycle: clear wins
    clr_i = 1'b1;
    cycles(2);
    do_load(16'h1234);
    check("clr_beats_load", {16'h0, bcd_o}, 32'h0);
    clr_i = 1'b0;
    cycles(3);

    // Loads landing on step cycles
    en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do_load(16'(i * 16'h0111));
      cycles(1);
    end

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      en_i       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_i = ~up_i;
      if ($urandom_range(0, 11) == 0) clr_i = ~clr_i;
      load_i     = ($urandom_range(0, 13) == 0);
      load_val_i = 16'($urandom_range(0, 16'hFFFF));
      @(negedge clk_i);
    end
    load_i = 1'b0;
    clr_i  = 1'b0;
    en_i   = 1'b1;
    up_i   = 1'b1;
    cycles(20);

    // Asynchronous reset mid-count, off a clock edge
    #3;
    rst_i = 1'b0;
    #1;
    check("async_rst_bcd", {16'h0, bcd_o}, 32'h0);
    check("async_rst_flags", {30'h0, tick_o, wrap_o}, 32'h0);
    cycles(2);
    rst_i = 1'b1;
    cycles(20);

    cycles(2);
    @(posedge clk_i);
    #2;
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_4d.md
Name: bcd_counter_4d

Overview:
Four-digit packed-BCD up/down counter that drives the 16-bit BCD input of the 4-digit 7-segment multiplexer.
- A prescaler divides clk_i down to a count tick.
- Switch/button inputs are synchronised on-chip.
- The count runs 0000..9999 with wrap-around in both directions.
- bcd_o connects directly to the display driver's bcd_i, with the least-significant digit in [3:0].

Parameters:
TICK_COUNT, 27000000, clk_i cycles per count step (1 Hz at 27 MHz); legal range >= 2; prescaler width = $clog2(TICK_COUNT).
SYNC_STAGES, 2, flip-flop depth of the input synchronisers for en_i, up_i, clr_i; legal range >= 2.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-low
en_i  in  1  run enable (level, asynchronous switch); 1 = counting, 0 = paused
up_i  in  1  direction (level, asynchronous switch); 1 = up, 0 = down
clr_i  in  1  clear button (asynchronous level); acts on its rising edge only
load_i  in  1  load strobe, synchronous to clk_i, one cycle
load_val_i  in  16  packed-BCD value for load, digit 0 in [3:0]
bcd_o  out  16  current count, packed BCD, registered
tick_o  out  1  one-cycle pulse in the same cycle bcd_o takes a tick-driven step
wrap_o  out  1  one-cycle pulse in the same cycle bcd_o wraps (9999->0000 or 0000->9999)

Behaviour:
- Reset (rst_i low, asynchronous assert, synchronous release) drives:
  - bcd_o=16'h0000, tick_o=0, wrap_o=0;
  - prescaler=TICK_COUNT-1;
  - all synchroniser flops and the clr edge register to 0.
- Synchronisers: en_i, up_i, clr_i each pass through SYNC_STAGES flops. en_s, up_s, clr_s denote the synchronised outputs. clr_pulse = clr_s & ~clr_s_d, exactly one cycle per press.
- load_i and load_val_i are not synchronised.
- Prescaler:
  - While en_s=1 it decrements each cycle.
  - When it is 0 and en_s=1: it reloads TICK_COUNT-1 and internal step=1.
  - While en_s=0 it holds its value (pause/resume keeps phase) and step=0.
  - Tick period is exactly TICK_COUNT cycles while enabled.
- Count update, evaluated each cycle with priority clr_pulse > load_i > step:
  - clr_pulse: bcd_o<=0000 and prescaler<=TICK_COUNT-1; tick_o=0, wrap_o=0.
  - load_i: each digit loads min(load_val_i digit, 9), so nibbles A-F clamp to 9. The prescaler is unaffected and tick_o=0, wrap_o=0. A step coinciding with a load is dropped.
  - step with up_s=1: ripple BCD increment. A digit at 9 becomes 0 and carries to the next digit. 9999->0000 asserts wrap_o.
  - step with up_s=0: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. 0000->9999 asserts wrap_o.
  - tick_o=1 whenever a step is applied.
- tick_o and wrap_o are registered and coincide with the bcd_o change. Both are 0 in all other cycles.
- up_s is sampled at the step cycle. A direction change mid-period takes effect at the next step with no extra step.
- Latency:
  - en_i rising to first step is SYNC_STAGES + (prescaler value + 1) cycles.
  - clr_i rising to bcd_o=0 is SYNC_STAGES+1 cycles.
  - load_i to bcd_o is 1 cycle.
- A held clr_i gives one clear only. The count resumes after one full TICK_COUNT period if en_s=1.
- Reset mid-period discards the prescaler phase. The first step after release, with en_s=1, occurs TICK_COUNT cycles after the synchronised enable.
- bcd_o never holds a non-BCD nibble.

Test Plan:
All scenarios use TICK_COUNT=4 and SYNC_STAGES=2.
- Reset, en_i=1, up_i=1 -> bcd_o steps 0000,0001,...; consecutive tick_o pulses exactly 4 cycles apart; 0009->0010, 0099->0100 carries correct.
- load 16'h9998, up -> bcd_o 9999 then 0000 with wrap_o=1 in that cycle only; down from 0000 -> 9999 with wrap_o=1; 1000 down -> 0999.
- en_i toggled 0 for 10 cycles mid-period -> no tick_o while paused; after resume, the remaining phase completes with no lost or extra step.
- clr_i held high 20 cycles at bcd_o=0042 -> bcd_o=0000 exactly 3 cycles after rising edge; counting resumes once; no repeat clears.
- load_val_i=16'hA5F3 -> bcd_o=16'h9593. load_i asserted in a step cycle -> load value taken, tick_o=0. clr and load together -> 0000.
- Assert rst_i low mid-count, including off a clock edge -> bcd_o, tick_o, wrap_o are 0 immediately. After release, first step is 4 cycles after en_s rises.
